// File: rtl/riscpipe_pkg.sv
// Constants shared by the pipeline-register stages (control, ID/EX, EX/MEM, MEM/WB)
// and the write-back end.
package riscpipe_pkg;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;
   localparam int REG_AW      = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   // x0 is the architectural zero register, so a write aimed at it never takes effect
   function automatic logic wb_write_enable(input logic [1:0] ctrl, input reg_addr_t rd);
      return ctrl[WB_REGWRITE] & (rd != REG_ZERO);
   endfunction

endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: asynchronously cleared array, one write port,
// two raw combinational read ports. No bypass or x0 handling lives here.
module regfile_core
   import riscpipe_pkg::*;
#(
   parameter int N    = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  reg_addr_t       waddr,
   input  logic [N-1:0]    wdata,
   input  reg_addr_t       raddr1,
   input  reg_addr_t       raddr2,
   output logic [N-1:0]    rdata1,
   output logic [N-1:0]    rdata2
);

   logic [N-1:0] regs_q [NREG];
   logic [N-1:0] regs_d [NREG];

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
         if (we && (waddr == reg_addr_t'(i))) begin
            regs_d[i] = wdata;
         end
      end
   end

   // Every register clears on rst without waiting for a clock edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign rdata1 = regs_q[raddr1];
   assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back end of MEM/WB: result select, x0 gating, write-first read bypass,
// and a free-running count of committed register writes.
module wb_regfile
   import riscpipe_pkg::*;
#(
   parameter int N    = 32,
   parameter int NREG = 32,
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      wb_ctrl,
   input  logic [4:0]      wb_rd,
   input  logic [N-1:0]    wb_memdata,
   input  logic [N-1:0]    wb_aluresult,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [N-1:0]    rs1_data,
   output logic [N-1:0]    rs2_data,
   output logic [N-1:0]    wb_data,
   output logic            wb_we,
   output logic [CNTW-1:0] wr_count
);

   logic [N-1:0]    raw1;
   logic [N-1:0]    raw2;
   logic            bypass_en;
   logic [CNTW-1:0] wr_count_q;
   logic [CNTW-1:0] wr_count_d;

   assign wb_data = wb_ctrl[WB_MEMTOREG] ? wb_memdata : wb_aluresult;
   assign wb_we   = wb_write_enable(wb_ctrl, wb_rd);

   regfile_core #(
      .N    (N),
      .NREG (NREG)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .we     (wb_we),
      .waddr  (wb_rd),
      .wdata  (wb_data),
      .raddr1 (rs1_addr),
      .raddr2 (rs2_addr),
      .rdata1 (raw1),
      .rdata2 (raw2)
   );

   // While reset is held nothing commits, so the bypass must not advertise a write either
   assign bypass_en = wb_we & ~rst;

   always_comb begin
      rs1_data = raw1;
      if (rs1_addr == REG_ZERO) begin
         rs1_data = '0;
      end else if (bypass_en && (rs1_addr == wb_rd)) begin
         rs1_data = wb_data;
      end
   end

   always_comb begin
      rs2_data = raw2;
      if (rs2_addr == REG_ZERO) begin
         rs2_data = '0;
      end else if (bypass_en && (rs2_addr == wb_rd)) begin
         rs2_data = wb_data;
      end
   end

   always_comb begin
      wr_count_d = wr_count_q;
      if (wb_we) begin
         wr_count_d = wr_count_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_q <= '0;
      end else begin
         wr_count_q <= wr_count_d;
      end
   end

   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed checks of the write-back register file plus a short randomised run
// against a golden array model; a second instance with a 4-bit counter covers wrap.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wb_ctrl;
   logic [4:0]  wb_rd;
   logic [31:0] wb_memdata;
   logic [31:0] wb_aluresult;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wb_data;
   logic        wb_we;
   logic [31:0] wr_count;

   logic [1:0]  c4_ctrl;
   logic [4:0]  c4_rd;
   logic [31:0] c4_alu;
   logic [4:0]  c4_rs1;
   logic [31:0] c4_rs1_data;
   logic [31:0] c4_rs2_data;
   logic [31:0] c4_wb_data;
   logic        c4_wb_we;
   logic [3:0]  c4_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [32];
   logic [31:0] model_cnt;

   always #5 clk = ~clk;

   wb_regfile #(.N(32), .NREG(32), .CNTW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_ctrl      (wb_ctrl),
      .wb_rd        (wb_rd),
      .wb_memdata   (wb_memdata),
      .wb_aluresult (wb_aluresult),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .wb_data      (wb_data),
      .wb_we        (wb_we),
      .wr_count     (wr_count)
   );

   wb_regfile #(.N(32), .NREG(32), .CNTW(4)) dut4 (
      .clk          (clk),
      .rst          (rst),
      .wb_ctrl      (c4_ctrl),
      .wb_rd        (c4_rd),
      .wb_memdata   (32'h0),
      .wb_aluresult (c4_alu),
      .rs1_addr     (c4_rs1),
      .rs2_addr     (5'd0),
      .rs1_data     (c4_rs1_data),
      .rs2_data     (c4_rs2_data),
      .wb_data      (c4_wb_data),
      .wb_we        (c4_wb_we),
      .wr_count     (c4_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      wb_ctrl = 2'b00; wb_rd = 5'd0; wb_memdata = '0; wb_aluresult = '0;
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      c4_ctrl = 2'b00; c4_rd = 5'd0; c4_alu = '0; c4_rs1 = 5'd0;
      #1;
      chk("reset_count", wr_count, 32'd0);
      chk("reset_we", {31'd0, wb_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1: write x5, then an asynchronous reset pulse between edges
      wb_ctrl = 2'b10; wb_rd = 5'd5; wb_aluresult = 32'hDEADBEEF;
      tick();
      wb_ctrl = 2'b00; rs1_addr = 5'd5;
      #1;
      chk("x5_written", rs1_data, 32'hDEADBEEF);
      chk("count_after_x5", wr_count, 32'd1);
      rst = 1'b1;
      #1;
      chk("x5_async_clear", rs1_data, 32'd0);
      chk("count_async_clear", wr_count, 32'd0);
      rst = 1'b0;
      $display("step reset: x5=%h count=%0d", rs1_data, wr_count);

      // 2: write-back mux
      @(negedge clk);
      wb_ctrl = 2'b11; wb_rd = 5'd7; wb_memdata = 32'h11; wb_aluresult = 32'h22;
      #1;
      chk("mux_mem_wbdata", wb_data, 32'h11);
      tick();
      wb_ctrl = 2'b00; rs1_addr = 5'd7;
      #1;
      chk("x7_mem", rs1_data, 32'h11);
      wb_ctrl = 2'b10; wb_rd = 5'd7;
      #1;
      chk("mux_alu_wbdata", wb_data, 32'h22);
      tick();
      wb_ctrl = 2'b00;
      #1;
      chk("x7_alu", rs1_data, 32'h22);
      chk("count_after_mux", wr_count, 32'd2);
      $display("step mux: x7=%h count=%0d", rs1_data, wr_count);

      // 3: x0 writes are dropped
      wb_ctrl = 2'b10; wb_rd = 5'd0; wb_aluresult = 32'hFFFF; rs1_addr = 5'd0;
      #1;
      chk("x0_we", {31'd0, wb_we}, 32'd0);
      chk("x0_read_before", rs1_data, 32'd0);
      tick();
      chk("x0_read_after", rs1_data, 32'd0);
      chk("x0_count", wr_count, 32'd2);
      $display("step x0: rs1=%h count=%0d", rs1_data, wr_count);

      // 4: both ports bypass in the same cycle
      wb_ctrl = 2'b10; wb_rd = 5'd3; wb_aluresult = 32'hABCD; rs1_addr = 5'd3; rs2_addr = 5'd3;
      #1;
      chk("bypass_rs1", rs1_data, 32'hABCD);
      chk("bypass_rs2", rs2_data, 32'hABCD);
      tick();
      wb_ctrl = 2'b00;
      #1;
      chk("x3_stored", rs1_data, 32'hABCD);
      chk("count_after_bypass", wr_count, 32'd3);
      $display("step bypass: rs1=%h rs2=%h", rs1_data, rs2_data);

      // 5: bubbles and MemtoReg-only control do not write
      wb_ctrl = 2'b00; wb_rd = 5'd4; wb_memdata = 32'h6666; wb_aluresult = 32'h5555;
      rs1_addr = 5'd4; rs2_addr = 5'd0;
      #1;
      chk("bubble_we", {31'd0, wb_we}, 32'd0);
      tick();
      chk("bubble_x4", rs1_data, 32'd0);
      wb_ctrl = 2'b01;
      #1;
      chk("memtoreg_only_we", {31'd0, wb_we}, 32'd0);
      chk("memtoreg_only_wbdata", wb_data, 32'h6666);
      tick();
      chk("memtoreg_only_x4", rs1_data, 32'd0);
      chk("bubble_count", wr_count, 32'd3);
      wb_ctrl = 2'b0x;
      #1;
      chk("xctrl_we", {31'd0, wb_we}, 32'd0);
      tick();
      wb_ctrl = 2'b00;
      #1;
      chk("xctrl_x4", rs1_data, 32'd0);
      chk("xctrl_count", wr_count, 32'd3);
      $display("step bubble: x4=%h count=%0d", rs1_data, wr_count);

      // Reset held across an edge drops the in-flight write; release commits on the next edge
      @(negedge clk);
      rst = 1'b1; wb_ctrl = 2'b10; wb_rd = 5'd9; wb_aluresult = 32'h1234; rs1_addr = 5'd9;
      #1;
      chk("rst_bypass_gated", rs1_data, 32'd0);
      tick();
      chk("rst_no_commit", rs1_data, 32'd0);
      chk("rst_count", wr_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_release_bypass", rs1_data, 32'h1234);
      tick();
      wb_ctrl = 2'b00;
      #1;
      chk("rst_release_commit", rs1_data, 32'h1234);
      chk("rst_release_count", wr_count, 32'd1);
      rs1_addr = 5'd7;
      #1;
      chk("x7_cleared_by_rst", rs1_data, 32'd0);
      $display("step reset-window: x9=%h count=%0d", 32'h1234, wr_count);

      // 6: 4-bit counter wraps after 16 commits
      @(negedge clk);
      c4_ctrl = 2'b10; c4_rd = 5'd1; c4_rs1 = 5'd1;
      for (int i = 1; i <= 17; i++) begin
         c4_alu = 32'(i);
         tick();
         if (i == 15) chk("c4_count_15", {28'd0, c4_count}, 32'd15);
         if (i == 16) chk("c4_count_wrap0", {28'd0, c4_count}, 32'd0);
      end
      c4_ctrl = 2'b00;
      #1;
      chk("c4_count_17", {28'd0, c4_count}, 32'd1);
      chk("c4_x1", c4_rs1_data, 32'd17);
      $display("step wrap: count4=%0d x1=%0d", c4_count, c4_rs1_data);

      // Randomised run against a golden model, starting from a fresh reset
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int r = 0; r < 32; r++) model[r] = '0;
      model_cnt = '0;
      for (int n = 0; n < 300; n++) begin
         logic [31:0] exp_wbd;
         logic        exp_we;
         logic [31:0] exp1;
         logic [31:0] exp2;
         @(negedge clk);
         wb_ctrl      = 2'($urandom_range(0, 3));
         wb_rd        = 5'($urandom_range(0, 7));
         wb_memdata   = $urandom;
         wb_aluresult = $urandom;
         rs1_addr     = 5'($urandom_range(0, 7));
         rs2_addr     = 5'($urandom_range(0, 7));
         #1;
         exp_wbd = wb_ctrl[0] ? wb_memdata : wb_aluresult;
         exp_we  = wb_ctrl[1] && (wb_rd != 5'd0);
         exp1 = (rs1_addr == 5'd0) ? 32'd0 :
                (exp_we && rs1_addr == wb_rd) ? exp_wbd : model[rs1_addr];
         exp2 = (rs2_addr == 5'd0) ? 32'd0 :
                (exp_we && rs2_addr == wb_rd) ? exp_wbd : model[rs2_addr];
         chk("rand_wbdata", wb_data, exp_wbd);
         chk("rand_we", {31'd0, wb_we}, {31'd0, exp_we});
         chk("rand_rs1", rs1_data, exp1);
         chk("rand_rs2", rs2_data, exp2);
         tick();
         if (exp_we) begin
            model[wb_rd] = exp_wbd;
            model_cnt    = model_cnt + 32'd1;
         end
         chk("rand_count", wr_count, model_cnt);
         if (n % 50 == 0) $display("rand step %0d: rd=%0d we=%0d count=%0d", n, wb_rd, exp_we, wr_count);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
